mcdf_arbiter: RTL and testbench



---
 rtl/mcdf_arbiter_if.sv | 30 +++
 rtl/mcdf_arbiter.sv | 145 ++++++++++++++
 tb/tb_mcdf_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcdf_arbiter_if.sv
// Channel-side and formatter-side signals of the MCDF arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mcdf_arbiter_if #(
  parameter int unsigned CHNL_NUM = 3,
  parameter int unsigned DW       = 32
);
  logic [CHNL_NUM-1:0]    chnl_en;
  logic [2*CHNL_NUM-1:0]  chnl_prio;
  logic [2*CHNL_NUM-1:0]  chnl_len;
  logic [CHNL_NUM-1:0]    chnl_valid;
  logic [CHNL_NUM*DW-1:0] chnl_data;
  logic [CHNL_NUM-1:0]    chnl_ready;
  logic                   fmt_valid;
  logic [DW-1:0]          fmt_data;
  logic [1:0]             fmt_chnl_id;
  logic                   fmt_sop;
  logic                   fmt_eop;
  logic                   fmt_ready;
  logic                   arb_busy;

  modport master (
    input  chnl_en, chnl_prio, chnl_len, chnl_valid, chnl_data, fmt_ready,
    output chnl_ready, fmt_valid, fmt_data, fmt_chnl_id, fmt_sop, fmt_eop, arb_busy
  );

  modport slave (
    output chnl_en, chnl_prio, chnl_len, chnl_valid, chnl_data, fmt_ready,
    input  chnl_ready, fmt_valid, fmt_data, fmt_chnl_id, fmt_sop, fmt_eop, arb_busy
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// Packet-granular priority arbiter from MCDF channel slaves to the formatter.
// Define MCDF_ARB_RR_EN for round-robin tie-break; otherwise ties go to the lowest index.
module mcdf_arbiter #(
  parameter int unsigned CHNL_NUM = 3,
  parameter int unsigned DW       = 32
) (
  input logic           clk,
  input logic           rst,
  mcdf_arbiter_if.master bus
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e         state_q, state_d;
  logic [1:0]     gnt_q;
  logic [5:0]     words_left_q, len_latched_q;
  logic           fmt_valid_q, fmt_sop_q, fmt_eop_q;
  logic [DW-1:0]  fmt_data_q;
  logic [1:0]     fmt_chnl_id_q;

  logic [CHNL_NUM-1:0] elig;
  logic [1:0]          prio_arr [CHNL_NUM];
  logic [1:0]          len_arr  [CHNL_NUM];
  logic [DW-1:0]       data_arr [CHNL_NUM];
  logic                win_found;
  logic [1:0]          win_idx, win_prio;
  logic                ready_gnt, accept;

  always_comb begin
    for (int i = 0; i < CHNL_NUM; i++) begin
      prio_arr[i] = bus.chnl_prio[2*i +: 2];
      len_arr[i]  = bus.chnl_len[2*i +: 2];
      data_arr[i] = bus.chnl_data[DW*i +: DW];
    end
  end

  assign elig = bus.chnl_en & bus.chnl_valid;

`ifdef MCDF_ARB_RR_EN
  logic [1:0] last_gnt_q;
  logic [2:0] rr_sum;
  logic [1:0] rr_idx;

  // Scan starting just after the previous grant; strict '<' keeps the first tied hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= CHNL_NUM; k++) begin
      rr_sum = {1'b0, last_gnt_q} + 3'(k);
      if (rr_sum >= 3'(CHNL_NUM)) rr_sum = rr_sum - 3'(CHNL_NUM);
      rr_idx = rr_sum[1:0];
      if (elig[rr_idx] && (!win_found || prio_arr[rr_idx] < win_prio)) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
        win_prio  = prio_arr[rr_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 2'(CHNL_NUM - 1);
    end else if (accept && words_left_q == 6'd1) begin
      last_gnt_q <= gnt_q;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      if (elig[i] && (!win_found || prio_arr[i] < win_prio)) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        win_prio  = prio_arr[i];
      end
    end
  end
`endif

  // No skid buffer: a word is only taken when the output register is free or draining.
  assign ready_gnt = (state_q == StXfer) && (words_left_q != 6'd0) &&
                     (!fmt_valid_q || bus.fmt_ready);
  assign accept    = ready_gnt && bus.chnl_valid[gnt_q];

  always_comb begin
    bus.chnl_ready        = '0;
    bus.chnl_ready[gnt_q] = ready_gnt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StXfer;
      StXfer:  if (accept && words_left_q == 6'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q         <= '0;
      words_left_q  <= '0;
      len_latched_q <= '0;
      fmt_valid_q   <= 1'b0;
      fmt_data_q    <= '0;
      fmt_chnl_id_q <= '0;
      fmt_sop_q     <= 1'b0;
      fmt_eop_q     <= 1'b0;
    end else begin
      if (state_q == StIdle && win_found) begin
        gnt_q         <= win_idx;
        words_left_q  <= 6'd4 << len_arr[win_idx];
        len_latched_q <= 6'd4 << len_arr[win_idx];
      end
      if (accept) begin
        words_left_q  <= words_left_q - 6'd1;
        fmt_valid_q   <= 1'b1;
        fmt_data_q    <= data_arr[gnt_q];
        fmt_chnl_id_q <= gnt_q;
        fmt_sop_q     <= (words_left_q == len_latched_q);
        fmt_eop_q     <= (words_left_q == 6'd1);
      end else if (bus.fmt_ready) begin
        fmt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fmt_valid   = fmt_valid_q;
  assign bus.fmt_data    = fmt_data_q;
  assign bus.fmt_chnl_id = fmt_chnl_id_q;
  assign bus.fmt_sop     = fmt_sop_q;
  assign bus.fmt_eop     = fmt_eop_q;
  assign bus.arb_busy    = (state_q == StXfer);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: counting slave models, an output logger and
// hand-computed expectations for reset, priority, tie-break, backpressure and disable.
module tb_mcdf_arbiter;
  localparam int unsigned CHNL_NUM = 3;
  localparam int unsigned DW       = 32;

  logic clk;
  logic rst;

  mcdf_arbiter_if #(.CHNL_NUM(CHNL_NUM), .DW(DW)) bus ();

  mcdf_arbiter #(.CHNL_NUM(CHNL_NUM), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave i presents base[i] + (words already taken), up to limit[i] words.
  logic [DW-1:0]       base  [CHNL_NUM];
  int unsigned         limit [CHNL_NUM];
  int unsigned         cnt   [CHNL_NUM];
  logic [CHNL_NUM-1:0] vld;

  always_comb begin
    for (int i = 0; i < CHNL_NUM; i++) begin
      bus.chnl_valid[i]           = vld[i] && (cnt[i] < limit[i]);
      bus.chnl_data[DW*i +: DW]   = base[i] + DW'(cnt[i]);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '{default: 0};
    end else begin
      for (int i = 0; i < CHNL_NUM; i++) begin
        if (bus.chnl_valid[i] && bus.chnl_ready[i]) cnt[i] <= cnt[i] + 1;
      end
    end
  end

  // Logs every word the formatter accepts, and counts busy cycles.
  logic [DW-1:0] log_data [64];
  logic [1:0]    log_id   [64];
  logic          log_sop  [64];
  logic          log_eop  [64];
  int            mon_n;
  int            busy_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_n    <= 0;
      busy_cnt <= 0;
    end else begin
      if (bus.fmt_valid && bus.fmt_ready && mon_n < 64) begin
        log_data[mon_n] <= bus.fmt_data;
        log_id[mon_n]   <= bus.fmt_chnl_id;
        log_sop[mon_n]  <= bus.fmt_sop;
        log_eop[mon_n]  <= bus.fmt_eop;
        mon_n           <= mon_n + 1;
      end
      if (bus.arb_busy) busy_cnt <= busy_cnt + 1;
    end
  end

  int vecs;
  int errs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_n(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (mon_n < target && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(mon_n >= target), 64'd1);
  endtask

  logic [1:0]    exp_id4, exp_id8;
  logic [DW-1:0] exp_d8;

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    vld  = '0;
    base  = '{32'hA00, 32'h10, 32'hC00};
    limit = '{0, 0, 0};
    bus.chnl_en   = '0;
    bus.chnl_prio = '0;
    bus.chnl_len  = '0;
    bus.fmt_ready = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_fmt_valid", 64'(bus.fmt_valid), 64'd0);
    chk("rst_fmt_data", 64'(bus.fmt_data), 64'd0);
    chk("rst_fmt_id", 64'(bus.fmt_chnl_id), 64'd0);
    chk("rst_fmt_sop", 64'(bus.fmt_sop), 64'd0);
    chk("rst_fmt_eop", 64'(bus.fmt_eop), 64'd0);
    chk("rst_chnl_ready", 64'(bus.chnl_ready), 64'd0);
    chk("rst_arb_busy", 64'(bus.arb_busy), 64'd0);

    // Single channel, len code 0, cycle-accurate timing
    rst = 1'b0;
    bus.fmt_ready = 1'b1;
    step();
    bus.chnl_en = 3'b010;
    limit[1]    = 4;
    vld         = 3'b010;
    chk("single_idle_busy", 64'(bus.arb_busy), 64'd0);
    step();
    chk("single_n1_busy", 64'(bus.arb_busy), 64'd1);
    chk("single_n1_ready", 64'(bus.chnl_ready), 64'h2);
    chk("single_n1_fvalid", 64'(bus.fmt_valid), 64'd0);
    step();
    chk("single_n2_fvalid", 64'(bus.fmt_valid), 64'd1);
    chk("single_n2_data", 64'(bus.fmt_data), 64'h10);
    chk("single_n2_id", 64'(bus.fmt_chnl_id), 64'd1);
    chk("single_n2_sop", 64'(bus.fmt_sop), 64'd1);
    chk("single_n2_eop", 64'(bus.fmt_eop), 64'd0);
    step();
    step();
    step();
    chk("single_n5_data", 64'(bus.fmt_data), 64'h13);
    chk("single_n5_eop", 64'(bus.fmt_eop), 64'd1);
    chk("single_n5_sop", 64'(bus.fmt_sop), 64'd0);
    chk("single_n5_busy", 64'(bus.arb_busy), 64'd0);
    step();
    chk("single_n6_fvalid", 64'(bus.fmt_valid), 64'd0);
    chk("single_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("single_word_count", 64'(mon_n), 64'd4);

    // Priority: ch2 (prio 0) beats ch0 (prio 2)
    do_reset();
    bus.chnl_en   = 3'b101;
    bus.chnl_prio = {2'd0, 2'd3, 2'd2};
    bus.chnl_len  = '0;
    limit = '{4, 0, 4};
    vld   = 3'b101;
    wait_n(8, 60, "prio_timeout");
    chk("prio_first_id", 64'(log_id[0]), 64'd2);
    chk("prio_first_data", 64'(log_data[0]), 64'hC00);
    chk("prio_second_id", 64'(log_id[4]), 64'd0);
    chk("prio_second_data", 64'(log_data[4]), 64'hA00);
    chk("prio_second_sop", 64'(log_sop[4]), 64'd1);
    chk("prio_second_eop", 64'(log_eop[7]), 64'd1);

    // Tie on priority, three packets
    do_reset();
    bus.chnl_en   = 3'b111;
    bus.chnl_prio = {2'd1, 2'd1, 2'd1};
    bus.chnl_len  = '0;
    limit = '{12, 12, 12};
    vld   = 3'b111;
`ifdef MCDF_ARB_RR_EN
    exp_id4 = 2'd1;
    exp_id8 = 2'd2;
    exp_d8  = 32'hC00;
`else
    exp_id4 = 2'd0;
    exp_id8 = 2'd0;
    exp_d8  = 32'hA08;
`endif
    wait_n(12, 80, "tie_timeout");
    chk("tie_pkt0_id", 64'(log_id[0]), 64'd0);
    chk("tie_pkt1_id", 64'(log_id[4]), 64'(exp_id4));
    chk("tie_pkt2_id", 64'(log_id[8]), 64'(exp_id8));
    chk("tie_pkt2_data", 64'(log_data[8]), 64'(exp_d8));
    chk("tie_pkt2_sop", 64'(log_sop[8]), 64'd1);

    // Backpressure: fmt_ready low for 3 cycles mid-packet
    do_reset();
    bus.chnl_en   = 3'b010;
    bus.chnl_prio = '0;
    bus.chnl_len  = {2'd0, 2'd1, 2'd0};
    limit = '{0, 8, 0};
    vld   = 3'b010;
    wait_n(3, 30, "bp_start_timeout");
    bus.fmt_ready = 1'b0;
    #1;
    chk("bp_hold0_ready", 64'(bus.chnl_ready), 64'd0);
    chk("bp_hold0_data", 64'(bus.fmt_data), 64'h13);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", 64'(bus.fmt_data), 64'h13);
      chk("bp_hold_valid", 64'(bus.fmt_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus.chnl_ready), 64'd0);
    end
    bus.fmt_ready = 1'b1;
    wait_n(8, 30, "bp_end_timeout");
    repeat (4) step();
    chk("bp_word_count", 64'(mon_n), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("bp_word_data", 64'(log_data[k]), 64'(32'h10 + 32'(k)));
    end
    chk("bp_sop", 64'(log_sop[0]), 64'd1);
    chk("bp_mid_eop", 64'(log_eop[3]), 64'd0);
    chk("bp_eop", 64'(log_eop[7]), 64'd1);

    // Disable ch0 after word 3 of 16: packet completes, no regrant
    do_reset();
    bus.chnl_en   = 3'b011;
    bus.chnl_prio = {2'd0, 2'd1, 2'd0};
    bus.chnl_len  = {2'd0, 2'd0, 2'd2};
    limit = '{32, 4, 0};
    vld   = 3'b011;
    wait_n(3, 30, "dis_start_timeout");
    bus.chnl_en = 3'b010;
    wait_n(20, 80, "dis_end_timeout");
    repeat (20) step();
    chk("dis_word_count", 64'(mon_n), 64'd20);
    chk("dis_last_id", 64'(log_id[15]), 64'd0);
    chk("dis_last_data", 64'(log_data[15]), 64'hA0F);
    chk("dis_last_eop", 64'(log_eop[15]), 64'd1);
    chk("dis_next_id", 64'(log_id[16]), 64'd1);
    chk("dis_next_sop", 64'(log_sop[16]), 64'd1);

    // Reset mid-packet after word 2 of 8
    do_reset();
    bus.chnl_en   = 3'b010;
    bus.chnl_prio = '0;
    bus.chnl_len  = {2'd0, 2'd1, 2'd0};
    limit = '{0, 16, 0};
    vld   = 3'b010;
    wait_n(2, 30, "rstx_start_timeout");
    chk("rstx_pre_eop", 64'(bus.fmt_eop), 64'd0);
    rst = 1'b1;
    step();
    chk("rstx_fmt_valid", 64'(bus.fmt_valid), 64'd0);
    chk("rstx_fmt_data", 64'(bus.fmt_data), 64'd0);
    chk("rstx_fmt_id", 64'(bus.fmt_chnl_id), 64'd0);
    chk("rstx_fmt_sop", 64'(bus.fmt_sop), 64'd0);
    chk("rstx_fmt_eop", 64'(bus.fmt_eop), 64'd0);
    chk("rstx_chnl_ready", 64'(bus.chnl_ready), 64'd0);
    chk("rstx_arb_busy", 64'(bus.arb_busy), 64'd0);
    rst = 1'b0;
    wait_n(8, 40, "rstx_end_timeout");
    chk("rstx_new_sop", 64'(log_sop[0]), 64'd1);
    chk("rstx_new_data", 64'(log_data[0]), 64'h10);
    chk("rstx_new_eop", 64'(log_eop[7]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
